// File: rtl/multiplier_control_n_if.sv
// Handshake bundle between the switch/button front end, the multiplier
// sequencer and the X:A:B register/adder datapath.
interface multiplier_control_n_if;
    logic LoadA;
    logic LoadB;
    logic Execute;
    logic M;
    logic Ld_A;
    logic Ld_B;
    logic Clr_XA;
    logic Add;
    logic Sub;
    logic Shift_En;
    logic Busy;
    logic Done;

    // master is the sequencer; slave is the surrounding front end plus datapath
    modport master (
        input  LoadA, LoadB, Execute, M,
        output Ld_A, Ld_B, Clr_XA, Add, Sub, Shift_En, Busy, Done
    );

    modport slave (
        output LoadA, LoadB, Execute, M,
        input  Ld_A, Ld_B, Clr_XA, Add, Sub, Shift_En, Busy, Done
    );
endinterface

// File: rtl/multiplier_control_n.sv
// Sequencer for a WIDTH-bit signed shift-add multiplier: CLEAR, then WIDTH
// ADD/SHIFT pairs driven by an iteration counter, then HOLD until Execute drops.
module multiplier_control_n #(
    parameter int WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    multiplier_control_n_if.master bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ADD,
        SHIFT,
        HOLD
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.Execute) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = ADD;
            end
            ADD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST_ITER) ? HOLD : ADD;
            end
            HOLD: begin
                // Execute is level-sensitive, so waiting for it to drop prevents an auto-restart
                if (!bus.Execute) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Final iteration subtracts: the multiplier MSB carries negative weight in two's complement
    always_comb begin
        bus.Ld_A     = 1'b0;
        bus.Ld_B     = 1'b0;
        bus.Clr_XA   = 1'b0;
        bus.Add      = 1'b0;
        bus.Sub      = 1'b0;
        bus.Shift_En = 1'b0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        case (state_q)
            IDLE: begin
                bus.Ld_A = bus.LoadA;
                bus.Ld_B = bus.LoadB;
            end
            CLEAR: begin
                bus.Clr_XA = 1'b1;
                bus.Busy   = 1'b1;
            end
            ADD: begin
                bus.Busy = 1'b1;
                bus.Add  = bus.M && (cnt_q < LAST_ITER);
                bus.Sub  = bus.M && (cnt_q == LAST_ITER);
            end
            SHIFT: begin
                bus.Shift_En = 1'b1;
                bus.Busy     = 1'b1;
            end
            HOLD: begin
                bus.Done = 1'b1;
            end
            default: begin
                bus.Busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplier_control_n.sv
// Self-checking bench: WIDTH=4, 8 and 16 sequencers share stimulus and are
// compared every cycle against a timeline reference model; WIDTH=8 also drives a datapath model.
module tb_multiplier_control_n;

    localparam int NI = 3;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset     = 1'b1;
    logic load_a    = 1'b0;
    logic load_b    = 1'b0;
    logic execute   = 1'b0;
    logic m_drv     = 1'b0;
    logic use_dp    = 1'b0;

    int errors = 0;
    int checks = 0;
    int wid[NI] = '{4, 8, 16};
    int phase[NI];

    // Datapath reference for the WIDTH=8 instance: X:A:B with multiplicand S
    logic       dp_x;
    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic [7:0] dp_s;
    logic [7:0] dp_a_load;
    logic [7:0] dp_b_load;

    multiplier_control_n_if if4 ();
    multiplier_control_n_if if8 ();
    multiplier_control_n_if if16 ();

    multiplier_control_n #(.WIDTH(4))  dut4  (.Clk(Clk), .Reset(Reset), .bus(if4));
    multiplier_control_n #(.WIDTH(8))  dut8  (.Clk(Clk), .Reset(Reset), .bus(if8));
    multiplier_control_n #(.WIDTH(16)) dut16 (.Clk(Clk), .Reset(Reset), .bus(if16));

    always_comb begin
        if4.LoadA    = load_a;
        if4.LoadB    = load_b;
        if4.Execute  = execute;
        if4.M        = m_drv;
        if8.LoadA    = load_a;
        if8.LoadB    = load_b;
        if8.Execute  = execute;
        if8.M        = use_dp ? dp_b[0] : m_drv;
        if16.LoadA   = load_a;
        if16.LoadB   = load_b;
        if16.Execute = execute;
        if16.M       = m_drv;
    end

    // Output vector order: {Ld_A, Ld_B, Clr_XA, Add, Sub, Shift_En, Busy, Done}
    logic [7:0] obs[NI];
    logic       m_act[NI];
    always_comb begin
        obs[0]   = {if4.Ld_A, if4.Ld_B, if4.Clr_XA, if4.Add, if4.Sub, if4.Shift_En, if4.Busy, if4.Done};
        obs[1]   = {if8.Ld_A, if8.Ld_B, if8.Clr_XA, if8.Add, if8.Sub, if8.Shift_En, if8.Busy, if8.Done};
        obs[2]   = {if16.Ld_A, if16.Ld_B, if16.Clr_XA, if16.Add, if16.Sub, if16.Shift_En, if16.Busy, if16.Done};
        m_act[0] = if4.M;
        m_act[1] = if8.M;
        m_act[2] = if16.M;
    end

    // Timeline model: phase 0 idle, 1 clear, 2..2w+1 alternating add/shift, 2w+2 hold
    function automatic int next_phase(int w, int p, logic rst, logic ex);
        if (rst) return 0;
        if (p == 0) return ex ? 1 : 0;
        if (p <= 2 * w + 1) return p + 1;
        return ex ? p : 0;
    endfunction

    function automatic logic [7:0] expect_out(int w, int p, logic la, logic lb, logic m);
        logic [7:0] e;
        int it;
        e = 8'h00;
        if (p == 0) begin
            e[7] = la;
            e[6] = lb;
        end else if (p == 1) begin
            e[5] = 1'b1;
            e[1] = 1'b1;
        end else if (p <= 2 * w + 1) begin
            e[1] = 1'b1;
            if (p % 2 == 0) begin
                it   = (p - 2) / 2;
                e[4] = m && (it < w - 1);
                e[3] = m && (it == w - 1);
            end else begin
                e[2] = 1'b1;
            end
        end else begin
            e[0] = 1'b1;
        end
        return e;
    endfunction

    task automatic tick();
        logic [7:0] c8;
        c8 = obs[1];
        @(posedge Clk);
        for (int i = 0; i < NI; i++) begin
            phase[i] = next_phase(wid[i], phase[i], Reset, execute);
        end
        if (c8[7]) dp_a = dp_a_load;
        if (c8[6]) dp_b = dp_b_load;
        if (c8[5]) {dp_x, dp_a} = 9'h000;
        if (c8[4]) {dp_x, dp_a} = {dp_a[7], dp_a} + {dp_s[7], dp_s};
        if (c8[3]) {dp_x, dp_a} = {dp_a[7], dp_a} - {dp_s[7], dp_s};
        if (c8[2]) {dp_x, dp_a, dp_b} = {dp_x, dp_x, dp_a, dp_b[7:1]};
        @(negedge Clk);
    endtask

    task automatic drain();
        load_a  = 1'b0;
        load_b  = 1'b0;
        execute = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (phase[0] == 0 && phase[1] == 0 && phase[2] == 0) break;
            tick();
        end
    endtask

    task automatic test_reset();
        Reset   = 1'b1;
        load_a  = 1'b0;
        load_b  = 1'b0;
        execute = 1'b0;
        tick();
        tick();
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_outputs W=%0d got %b want 00000000", wid[i], obs[i]);
            end
        end
        Reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            logic [7:0] e;
            e = expect_out(wid[i], phase[i], load_a, load_b, m_act[i]);
            checks++;
            if (obs[i] !== e) begin
                errors++;
                $display("[TB] FAIL reset_release W=%0d got %b want %b", wid[i], obs[i], e);
            end
        end
        tick();
    endtask

    task automatic test_loads();
        logic [1:0] pat[4] = '{2'b10, 2'b01, 2'b11, 2'b00};
        for (int k = 0; k < 4; k++) begin
            {load_a, load_b} = pat[k];
            #1;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs[i][7:6] !== pat[k] || obs[i][5:0] !== 6'b0) begin
                    errors++;
                    $display("[TB] FAIL idle_load W=%0d got %b want %b000000", wid[i], obs[i], pat[k]);
                end
            end
            tick();
        end
        execute = 1'b1;
        tick();
        execute = 1'b0;
        for (int c = 0; c < 14; c++) begin
            load_a = 1'($urandom_range(0, 1));
            load_b = 1'($urandom_range(0, 1));
            m_drv  = 1'($urandom_range(0, 1));
            #1;
            for (int i = 0; i < NI; i++) begin
                logic [7:0] e;
                e = expect_out(wid[i], phase[i], load_a, load_b, m_act[i]);
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("[TB] FAIL busy_load W=%0d c=%0d got %b want %b", wid[i], c, obs[i], e);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_pulse_run();
        int shifts[NI];
        int busy[NI];
        int adds[NI];
        int subs[NI];
        int sub_cyc[NI];
        int done_cyc[NI];
        for (int i = 0; i < NI; i++) begin
            shifts[i] = 0; busy[i] = 0; adds[i] = 0; subs[i] = 0; sub_cyc[i] = -1; done_cyc[i] = -1;
        end
        m_drv = 1'b1;
        for (int c = 0; c < 40; c++) begin
            execute = (c == 0);
            #1;
            for (int i = 0; i < NI; i++) begin
                logic [7:0] e;
                e = expect_out(wid[i], phase[i], load_a, load_b, m_act[i]);
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("[TB] FAIL pulse_cycle W=%0d c=%0d got %b want %b", wid[i], c, obs[i], e);
                end
                shifts[i] += int'(obs[i][2]);
                busy[i]   += int'(obs[i][1]);
                adds[i]   += int'(obs[i][4]);
                if (obs[i][3] === 1'b1) begin
                    subs[i]++;
                    sub_cyc[i] = c;
                end
                if (obs[i][0] === 1'b1 && done_cyc[i] < 0) done_cyc[i] = c;
            end
            tick();
        end
        for (int i = 0; i < NI; i++) begin
            int w;
            w = wid[i];
            checks++;
            if (shifts[i] != w || busy[i] != 2 * w + 1 || adds[i] != w - 1) begin
                errors++;
                $display("[TB] FAIL pulse_counts W=%0d shifts=%0d busy=%0d adds=%0d want %0d/%0d/%0d",
                         w, shifts[i], busy[i], adds[i], w, 2 * w + 1, w - 1);
            end
            checks++;
            if (subs[i] != 1 || sub_cyc[i] != 2 * w) begin
                errors++;
                $display("[TB] FAIL pulse_sub W=%0d count=%0d at=%0d want 1 at %0d", w, subs[i], sub_cyc[i], 2 * w);
            end
            checks++;
            if (done_cyc[i] != 2 * w + 2) begin
                errors++;
                $display("[TB] FAIL pulse_done W=%0d got cycle %0d want %0d", w, done_cyc[i], 2 * w + 2);
            end
        end
        drain();
    endtask

    task automatic test_signed_datapath();
        logic signed [7:0]  s_val[5];
        logic signed [7:0]  b_val[5];
        logic signed [15:0] want;
        s_val[0] = 8'sd7;
        b_val[0] = -8'sd3;
        for (int k = 1; k < 5; k++) begin
            s_val[k] = 8'($urandom);
            b_val[k] = 8'($urandom);
        end
        use_dp = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dp_s      = s_val[k];
            dp_b_load = b_val[k];
            load_b    = 1'b1;
            #1;
            tick();
            load_b = 1'b0;
            for (int c = 0; c < 24; c++) begin
                execute = (c == 0);
                m_drv   = 1'($urandom_range(0, 1));
                #1;
                for (int i = 0; i < NI; i++) begin
                    logic [7:0] e;
                    e = expect_out(wid[i], phase[i], load_a, load_b, m_act[i]);
                    checks++;
                    if (obs[i] !== e) begin
                        errors++;
                        $display("[TB] FAIL dp_cycle W=%0d c=%0d got %b want %b", wid[i], c, obs[i], e);
                    end
                end
                tick();
            end
            want = s_val[k] * b_val[k];
            checks++;
            if ({dp_a, dp_b} !== want) begin
                errors++;
                $display("[TB] FAIL dp_product %0d*%0d got %0d want %0d",
                         s_val[k], b_val[k], $signed({dp_a, dp_b}), want);
            end
        end
        use_dp = 1'b0;
        drain();
    endtask

    task automatic test_execute_held();
        int adds_subs;
        int last_done[NI];
        int shifts[NI];
        adds_subs = 0;
        for (int i = 0; i < NI; i++) begin
            last_done[i] = -1;
            shifts[i]    = 0;
        end
        m_drv = 1'b0;
        for (int c = 0; c < 45; c++) begin
            execute = (c < 40);
            #1;
            for (int i = 0; i < NI; i++) begin
                logic [7:0] e;
                e = expect_out(wid[i], phase[i], load_a, load_b, m_act[i]);
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("[TB] FAIL held_cycle W=%0d c=%0d got %b want %b", wid[i], c, obs[i], e);
                end
                adds_subs += int'(obs[i][4]) + int'(obs[i][3]);
                if (obs[i][0] === 1'b1) last_done[i] = c;
            end
            tick();
        end
        checks++;
        if (adds_subs != 0) begin
            errors++;
            $display("[TB] FAIL held_no_add add/sub pulses=%0d want 0", adds_subs);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (last_done[i] != 40) begin
                errors++;
                $display("[TB] FAIL held_done_end W=%0d last Done cycle %0d want 40", wid[i], last_done[i]);
            end
        end
        for (int c = 0; c < 40; c++) begin
            execute = (c == 0);
            #1;
            for (int i = 0; i < NI; i++) shifts[i] += int'(obs[i][2]);
            tick();
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (shifts[i] != wid[i]) begin
                errors++;
                $display("[TB] FAIL held_rerun W=%0d shifts=%0d want %0d", wid[i], shifts[i], wid[i]);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_run();
        int shifts[NI];
        for (int i = 0; i < NI; i++) shifts[i] = 0;
        for (int c = 0; c < 6; c++) begin
            execute = (c == 0);
            tick();
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i][2:1] !== 2'b00 || obs[i] !== expect_out(wid[i], phase[i], load_a, load_b, m_act[i])) begin
                errors++;
                $display("[TB] FAIL midreset_idle W=%0d got %b want 00000000", wid[i], obs[i]);
            end
        end
        for (int c = 0; c < 40; c++) begin
            execute = (c == 0);
            #1;
            for (int i = 0; i < NI; i++) shifts[i] += int'(obs[i][2]);
            tick();
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (shifts[i] != wid[i]) begin
                errors++;
                $display("[TB] FAIL midreset_rerun W=%0d shifts=%0d want %0d", wid[i], shifts[i], wid[i]);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            load_a  = 1'($urandom_range(0, 1));
            load_b  = 1'($urandom_range(0, 1));
            m_drv   = 1'($urandom_range(0, 1));
            execute = ($urandom_range(0, 3) == 0);
            Reset   = ($urandom_range(0, 49) == 0);
            #1;
            for (int i = 0; i < NI; i++) begin
                logic [7:0] e;
                e = expect_out(wid[i], phase[i], load_a, load_b, m_act[i]);
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("[TB] FAIL random_cycle W=%0d c=%0d got %b want %b", wid[i], c, obs[i], e);
                end
            end
            tick();
        end
        Reset = 1'b0;
        drain();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) phase[i] = 0;
        dp_x      = 1'b0;
        dp_a      = 8'h00;
        dp_b      = 8'h00;
        dp_s      = 8'h00;
        dp_a_load = 8'h00;
        dp_b_load = 8'h00;
        @(negedge Clk);
        test_reset();
        test_loads();
        test_pulse_run();
        test_signed_datapath();
        test_execute_held();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
